// File: rtl/hazard_stall_controller.sv
// Hazard sequencing for the 5-stage pipeline: load-use bubbles, taken-branch flushes
// and data-memory wait freezes with a halting timeout, plus saturating perf counters.
module hazard_stall_controller #(
    parameter int REG_W       = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int ZERO_REG    = 31
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_WriteRegister,
    input  logic [REG_W-1:0] IFID_rm,
    input  logic [REG_W-1:0] IFID_rn,
    input  logic             EXMEM_BranchTaken,
    input  logic             EXMEM_MemAccess,
    input  logic             DMem_Ready,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             PipeFreeze,
    output logic             Halted,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [7:0]       TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [REG_W-1:0] ZREG         = REG_W'(ZERO_REG);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic mem_wait;
    logic load_use;
    logic decode;

    assign mem_wait = EXMEM_MemAccess && !DMem_Ready;
    assign load_use = IDEX_MemRead && (IDEX_WriteRegister != ZREG) &&
                      ((IDEX_WriteRegister == IFID_rm) || (IDEX_WriteRegister == IFID_rn));

    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        IDEX_Flush  = 1'b0;
        EXMEM_Flush = 1'b0;
        PipeFreeze  = 1'b0;
        Halted      = 1'b0;
        decode      = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;

        if (Reset) begin
            PipeFreeze = 1'b1;
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            state_d    = RUN;
            wait_d     = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        PipeFreeze = 1'b1;
                        PCWrite    = 1'b0;
                        IFID_Write = 1'b0;
                        wait_d     = 8'd1;
                        state_d    = (MEM_TIMEOUT == 1) ? HALT : MEM_WAIT;
                    end else begin
                        decode = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Frozen registers keep any branch/load-use until release.
                    if (!DMem_Ready) begin
                        PipeFreeze = 1'b1;
                        PCWrite    = 1'b0;
                        IFID_Write = 1'b0;
                        wait_d     = wait_q + 8'd1;
                        if (wait_q == TIMEOUT_LAST) state_d = HALT;
                    end else begin
                        decode  = 1'b1;
                        state_d = RUN;
                        wait_d  = '0;
                    end
                end
                HALT: begin
                    PipeFreeze = 1'b1;
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    Halted     = 1'b1;
                end
                default: state_d = RUN;
            endcase

            if (decode) begin
                if (EXMEM_BranchTaken) begin
                    IFID_Flush  = 1'b1;
                    IDEX_Flush  = 1'b1;
                    EXMEM_Flush = 1'b1;
                end else if (load_use) begin
                    PCWrite     = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if ((PipeFreeze || IDEX_Bubble) && (stall_q != '1)) stall_d = stall_q + 1'b1;
        if (IFID_Flush && (flush_q != '1))                  flush_d = flush_q + 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign StallCycles = stall_q;
    assign FlushCount  = flush_q;

endmodule
